vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter HDISP, default 800, active pixels per line.
REQ-002 Parameter VDISP, default 480, active lines per frame.
REQ-003 Parameters HFP/HPULSE/HBP, defaults 40/48/40, horizontal front porch, sync pulse and back porch in pixel clocks.
REQ-004 Parameters VFP/VPULSE/VBP, defaults 13/3/29, vertical front porch, sync pulse and back porch in lines.
REQ-005 clk  input  1  pixel clock; the only clock of the block.
REQ-006 nrst  input  1  asynchronous, active-low reset.
REQ-007 fifo_rdata  input  24  show-ahead pixel FIFO head, {R,G,B} 8 bits each, valid whenever fifo_empty=0.
REQ-008 fifo_empty  input  1  pixel FIFO empty.
REQ-009 fifo_rd  output  1  pop strobe; pops one word per cycle asserted.
REQ-010 vga_hs  output  1  horizontal sync, active low.
REQ-011 vga_vs  output  1  vertical sync, active low.
REQ-012 vga_blank  output  1  1 = active display pixel, 0 = blanking.
REQ-013 vga_rgb  output  24  pixel colour {R,G,B}.
REQ-014 frame_start  output  1  one-cycle pulse when counters are at x=0, y=0.
REQ-015 underflow_cnt  output  16  saturating count of active pixels shown while FIFO empty in RUN state.

Function
REQ-016 HBLANK=HFP+HPULSE+HBP, HTOTAL=HBLANK+HDISP; VBLANK and VTOTAL are derived in the same way; counter widths are $clog2 of the totals.
REQ-017 x counts 0..HTOTAL-1 each clk and wraps to 0; y increments at each x wrap and wraps from VTOTAL-1 to 0.
REQ-018 Horizontal region order: front porch [0,HFP), sync [HFP,HFP+HPULSE), back porch, display [HBLANK,HTOTAL); vertical regions follow the same order in lines.
REQ-019 Active region: x>=HBLANK and y>=VBLANK.
REQ-020 vga_hs, vga_vs, vga_blank and vga_rgb are registered and decoded from the current x/y, giving a latency of exactly 1 clk from counter value to output.
REQ-021 frame_start is combinational from the counters (x==0 and y==0).
REQ-022 FSM states: WAIT_SYNC and RUN.
REQ-023 WAIT_SYNC to RUN transition occurs only in a cycle with frame_start=1 and fifo_empty=0; no other transitions exist except reset.
REQ-024 In WAIT_SYNC: fifo_rd=0 and vga_rgb is registered as 0, including in the active region.
REQ-025 In RUN: fifo_rd = active and not fifo_empty, combinationally in the same cycle; vga_rgb is registered from fifo_rdata when fifo_rd=1.
REQ-026 In RUN, an active pixel with fifo_empty=1 gives fifo_rd=0, vga_rgb registered as 0, and underflow_cnt incremented by 1.
REQ-027 underflow_cnt saturates at 16'hFFFF and never wraps.
REQ-028 In RUN, a blanking pixel gives fifo_rd=0 and vga_rgb registered as 0, independent of fifo_empty.
REQ-029 fifo_rd is never asserted when fifo_empty=1.
REQ-030 Timing generation runs identically in both states; the FSM state never alters hs, vs or blank.

Reset
REQ-031 nrst low asynchronously forces: x=0, y=0, state=WAIT_SYNC, vga_hs=1, vga_vs=1, vga_blank=0, vga_rgb=0, underflow_cnt=0.
REQ-032 During reset fifo_rd=0; frame_start equals 1, since x=y=0.
REQ-033 Reset mid-frame abandons the frame; after release the next frame_start with a non-empty FIFO re-enters RUN.
REQ-034 nrst is released synchronously by the instantiating level; the block itself adds no synchronizer.

Structure
REQ-035 A shared package vga_pkg holds the state enum type (WAIT_SYNC, RUN) and the default timing constants.
REQ-036 One sub-module, sync_counter, implements the parameterised wrapping x/y counter pair and exports x, y and the line-wrap event.
REQ-037 The top level of the controller connects these outputs to the video interface (CLK, HS, VS, BLANK, RGB).

Verification
Bench parameters: HDISP=4, VDISP=2, all porches and pulses = 1, giving HTOTAL=7, VTOTAL=5 and 35 clk per frame.
REQ-038 Reset release with FIFO always empty -> hs low for exactly 1 of every 7 clk; vs low for 7 clk per 35; blank high 8 clk per frame; fifo_rd never asserted; vga_rgb=0.
REQ-039 FIFO preloaded with 0x000001..0x000008 before the first frame_start -> RUN entered; exactly 8 pops per frame; vga_rgb shows 1..8 in order, each 1 clk after its pop, coinciding with blank=1.
REQ-040 FIFO runs dry after 5 pixels in RUN -> pixels 6..8 output 0; underflow_cnt=3; state stays RUN; the next non-empty pixel is displayed normally.
REQ-041 Permanent empty in RUN for 70000 active pixels -> underflow_cnt holds at 0xFFFF.
REQ-042 nrst pulsed low at x=5, y=3 -> outputs reach reset values immediately without waiting for clk; state is WAIT_SYNC; reads resume only from the next frame_start with FIFO non-empty.
REQ-043 FIFO becomes non-empty mid-frame while in WAIT_SYNC -> no pop until the following frame_start.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and default 800x480 timing for the VGA timing generator.
package vga_pkg;

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        RUN       = 1'b1
    } state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int DEF_HDISP  = 800;
    localparam int DEF_VDISP  = 480;
    localparam int DEF_HFP    = 40;
    localparam int DEF_HPULSE = 48;
    localparam int DEF_HBP    = 40;
    localparam int DEF_VFP    = 13;
    localparam int DEF_VPULSE = 3;
    localparam int DEF_VBP    = 29;

    localparam logic [15:0] UFLOW_MAX = 16'hFFFF;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel FIFO read side plus video outputs of the timing generator.
interface vga_timing_gen_if;
    import vga_pkg::*;

    rgb_t        fifo_rdata;
    logic        fifo_empty;
    logic        fifo_rd;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank;
    rgb_t        vga_rgb;
    logic        frame_start;
    logic [15:0] underflow_cnt;

    modport master (
        input  fifo_rdata, fifo_empty,
        output fifo_rd, vga_hs, vga_vs, vga_blank, vga_rgb, frame_start, underflow_cnt
    );

    modport slave (
        output fifo_rdata, fifo_empty,
        input  fifo_rd, vga_hs, vga_vs, vga_blank, vga_rgb, frame_start, underflow_cnt
    );

endinterface

// File: rtl/vga_timing_gen_sync_counter.sv
// Wrapping pixel (x) / line (y) counter pair; x wraps at HTOTAL, y steps on each x wrap.
// Latency: outputs are the registered counter values; line_wrap is combinational from x.
// Backpressure: none, free-running every clock.
module sync_counter #(
    parameter int HTOTAL = 7,
    parameter int VTOTAL = 5,
    parameter int XW     = 3,
    parameter int YW     = 3
) (
    input  logic          clk,
    input  logic          nrst,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_wrap
);

    localparam logic [XW-1:0] X_LAST = XW'(HTOTAL - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(VTOTAL - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    always_comb begin
        line_wrap = (x_q == X_LAST);
        x_d       = line_wrap ? '0 : x_q + 1'b1;
        y_d       = y_q;
        if (line_wrap) begin
            y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x = x_q;
    assign y = y_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: sync/blank decode and pixel FIFO drain, locked to frame start.
// Latency: hs/vs/blank/rgb 1 clk after counters; fifo_rd and frame_start combinational.
// Backpressure: none upstream; an empty FIFO in the active region shows black and counts an underflow.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int HDISP  = DEF_HDISP,
    parameter int VDISP  = DEF_VDISP,
    parameter int HFP    = DEF_HFP,
    parameter int HPULSE = DEF_HPULSE,
    parameter int HBP    = DEF_HBP,
    parameter int VFP    = DEF_VFP,
    parameter int VPULSE = DEF_VPULSE,
    parameter int VBP    = DEF_VBP
) (
    input  logic      clk,
    input  logic      nrst,
    vga_timing_gen_if.master vif
);

    localparam int HBLANK = HFP + HPULSE + HBP;
    localparam int HTOTAL = HBLANK + HDISP;
    localparam int VBLANK = VFP + VPULSE + VBP;
    localparam int VTOTAL = VBLANK + VDISP;
    localparam int XW     = $clog2(HTOTAL);
    localparam int YW     = $clog2(VTOTAL);

    localparam logic [XW-1:0] HS_START = XW'(HFP);
    localparam logic [XW-1:0] HS_END   = XW'(HFP + HPULSE);
    localparam logic [XW-1:0] H_ACT    = XW'(HBLANK);
    localparam logic [YW-1:0] VS_START = YW'(VFP);
    localparam logic [YW-1:0] VS_END   = YW'(VFP + VPULSE);
    localparam logic [YW-1:0] V_ACT    = YW'(VBLANK);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          line_wrap_unused;
    logic          active;
    logic          frame_start;
    logic          fifo_rd;

    state_e        state_q, state_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          blank_q, blank_d;
    rgb_t          rgb_q, rgb_d;
    logic [15:0]   ucnt_q, ucnt_d;

    sync_counter #(
        .HTOTAL (HTOTAL),
        .VTOTAL (VTOTAL),
        .XW     (XW),
        .YW     (YW)
    ) u_sync_counter (
        .clk       (clk),
        .nrst      (nrst),
        .x         (x),
        .y         (y),
        .line_wrap (line_wrap_unused)
    );

    // Timing decode is state-independent so sync stays stable while waiting for data.
    always_comb begin
        active      = (x >= H_ACT) && (y >= V_ACT);
        frame_start = (x == '0) && (y == '0);
        hs_d        = !((x >= HS_START) && (x < HS_END));
        vs_d        = !((y >= VS_START) && (y < VS_END));
        blank_d     = active;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= WAIT_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Only lock on at a frame boundary so the first popped word lands on pixel (0,0).
    always_comb begin
        state_d = state_q;
        if ((state_q == WAIT_SYNC) && frame_start && !vif.fifo_empty) begin
            state_d = RUN;
        end
    end

    always_comb begin
        fifo_rd = (state_q == RUN) && active && !vif.fifo_empty;
        rgb_d   = fifo_rd ? vif.fifo_rdata : '0;
        ucnt_d  = ucnt_q;
        if ((state_q == RUN) && active && vif.fifo_empty && (ucnt_q != UFLOW_MAX)) begin
            ucnt_d = ucnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            rgb_q   <= '0;
            ucnt_q  <= '0;
        end else begin
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            rgb_q   <= rgb_d;
            ucnt_q  <= ucnt_d;
        end
    end

    assign vif.fifo_rd       = fifo_rd;
    assign vif.frame_start   = frame_start;
    assign vif.vga_hs        = hs_q;
    assign vif.vga_vs        = vs_q;
    assign vif.vga_blank     = blank_q;
    assign vif.vga_rgb       = rgb_q;
    assign vif.underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small 7x5 raster against a frame-arithmetic reference model,
// plus a second large-raster instance that drives the underflow counter into saturation.
module tb_vga_timing_gen;

    localparam int HT = 7;
    localparam int VT = 5;
    localparam int FR = HT * VT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nrst;
    logic s_nrst;

    vga_timing_gen_if vif ();
    vga_timing_gen_if svif ();

    vga_timing_gen #(
        .HDISP(4), .VDISP(2), .HFP(1), .HPULSE(1), .HBP(1), .VFP(1), .VPULSE(1), .VBP(1)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .vif  (vif)
    );

    vga_timing_gen #(
        .HDISP(253), .VDISP(285), .HFP(1), .HPULSE(1), .HBP(1), .VFP(1), .VPULSE(1), .VBP(1)
    ) dut_sat (
        .clk  (clk),
        .nrst (s_nrst),
        .vif  (svif)
    );

    int checks   = 0;
    int failures = 0;

    // reference model state for the small raster
    int          t;
    bit          run;
    logic [23:0] q[$];
    logic        exp_hs, exp_vs, exp_blank;
    logic [23:0] exp_rgb;
    int          exp_cnt;

    int          n_hs_lo, n_vs_lo, n_blank, n_rd;
    logic [23:0] shown[$];
    logic [23:0] ev[$];

    bit          s_done = 1'b0;
    int          s_rd   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_act(int tt, int ht, int vt, int hb, int vb);
        return ((tt % ht) >= hb) && (((tt / ht) % vt) >= vb);
    endfunction

    task automatic drive_fifo();
        vif.fifo_empty = (q.size() == 0);
        vif.fifo_rdata = (q.size() != 0) ? q[0] : 24'($urandom);
    endtask

    task automatic push(input logic [23:0] v);
        q.push_back(v);
        drive_fifo();
    endtask

    task automatic reset_model();
        t         = 0;
        run       = 1'b0;
        exp_hs    = 1'b1;
        exp_vs    = 1'b1;
        exp_blank = 1'b0;
        exp_rgb   = '0;
        exp_cnt   = 0;
        q.delete();
        drive_fifo();
    endtask

    task automatic clr_stats();
        n_hs_lo = 0;
        n_vs_lo = 0;
        n_blank = 0;
        n_rd    = 0;
        shown.delete();
    endtask

    task automatic check_reset_now(input string tag);
        chk({tag, "_hs"},    vif.vga_hs, 1);
        chk({tag, "_vs"},    vif.vga_vs, 1);
        chk({tag, "_blank"}, vif.vga_blank, 0);
        chk({tag, "_rgb"},   vif.vga_rgb, 0);
        chk({tag, "_ucnt"},  vif.underflow_cnt, 0);
        chk({tag, "_rd"},    vif.fifo_rd, 0);
        chk({tag, "_fs"},    vif.frame_start, 1);
    endtask

    // One pixel clock: compare at the falling edge, then advance the model past the rising edge.
    task automatic tick();
        int x, y;
        bit act, fs, rd, nrun;
        @(negedge clk);
        x    = t % HT;
        y    = (t / HT) % VT;
        act  = (x >= 3) && (y >= 3);
        fs   = (x == 0) && (y == 0);
        rd   = run && act && (q.size() != 0);
        chk("frame_start", vif.frame_start, fs);
        chk("fifo_rd",     vif.fifo_rd, rd);
        chk("hs",          vif.vga_hs, exp_hs);
        chk("vs",          vif.vga_vs, exp_vs);
        chk("blank",       vif.vga_blank, exp_blank);
        chk("rgb",         vif.vga_rgb, exp_rgb);
        chk("ucnt",        vif.underflow_cnt, exp_cnt);
        if (!vif.vga_hs)   n_hs_lo++;
        if (!vif.vga_vs)   n_vs_lo++;
        if (vif.fifo_rd)   n_rd++;
        if (vif.vga_blank) begin
            n_blank++;
            shown.push_back(vif.vga_rgb);
        end
        exp_hs    = !((x >= 1) && (x < 2));
        exp_vs    = !((y >= 1) && (y < 2));
        exp_blank = act;
        exp_rgb   = rd ? q[0] : 24'd0;
        if (run && act && (q.size() == 0) && (exp_cnt < 65535)) exp_cnt++;
        nrun = run || (fs && (q.size() != 0));
        if (rd) void'(q.pop_front());
        run = nrun;
        @(posedge clk);
        #1;
        t++;
        drive_fifo();
    endtask

    task automatic run_until(input int target);
        for (int i = 0; (i < 4 * FR) && (t != target); i++) tick();
    endtask

    initial begin
        logic [23:0] v;
        int guard;
        nrst = 1'b1;
        q.delete();
        drive_fifo();
        #1 nrst = 1'b0;
        #11;
        check_reset_now("rst");
        @(posedge clk);
        #1;
        nrst = 1'b1;
        reset_model();

        // idle with empty FIFO: sync cadence only, nothing popped or shown
        run_until(FR);
        clr_stats();
        run_until(2 * FR);
        chk("idle_hs_lo",  n_hs_lo, 5);
        chk("idle_vs_lo",  n_vs_lo, 7);
        chk("idle_blank",  n_blank, 8);
        chk("idle_rd",     n_rd, 0);
        chk("idle_nshown", shown.size(), 8);
        for (int i = 0; i < shown.size(); i++) chk("idle_rgb", shown[i], 0);

        // data arrives mid-frame while waiting: held until the next frame start
        run_until(80);
        for (int i = 1; i <= 8; i++) push(24'(i));
        clr_stats();
        run_until(105);
        chk("wait_nopop", n_rd, 0);
        run_until(106);
        clr_stats();
        run_until(141);
        chk("run_pops",   n_rd, 8);
        chk("run_nshown", shown.size(), 8);
        for (int i = 0; i < shown.size(); i++) chk("run_rgb", shown[i], i + 1);

        // FIFO runs dry after 5 pixels
        ev.delete();
        for (int i = 0; i < 5; i++) begin
            v = 24'($urandom);
            ev.push_back(v);
            push(v);
        end
        clr_stats();
        run_until(176);
        chk("dry_pops",   n_rd, 5);
        chk("dry_ucnt",   vif.underflow_cnt, 3);
        chk("dry_nshown", shown.size(), 8);
        for (int i = 0; i < shown.size(); i++) chk("dry_rgb", shown[i], (i < 5) ? ev[i] : 24'd0);

        // refill mid-frame: still in RUN, so it displays in this same frame
        run_until(185);
        ev.delete();
        for (int i = 0; i < 8; i++) begin
            v = 24'($urandom);
            ev.push_back(v);
            push(v);
        end
        clr_stats();
        run_until(211);
        chk("refill_pops",   n_rd, 8);
        chk("refill_ucnt",   vif.underflow_cnt, 3);
        chk("refill_nshown", shown.size(), 8);
        for (int i = 0; i < shown.size(); i++) chk("refill_rgb", shown[i], ev[i]);

        // random producer against the model
        for (int i = 0; i < 4 * FR; i++) begin
            if ($urandom_range(0, 3) == 0) push(24'($urandom));
            tick();
        end

        // asynchronous reset at x=5, y=3 with data in flight
        for (int i = 0; (i < FR) && ((t % FR) != 0); i++) tick();
        for (int i = 0; i < 16; i++) push(24'($urandom));
        for (int i = 0; (i < FR) && ((t % FR) != 26); i++) tick();
        chk("pre_arst_blank", vif.vga_blank, 1);
        #2;
        nrst = 1'b0;
        #1;
        check_reset_now("arst");
        @(posedge clk);
        #1;
        nrst = 1'b1;
        reset_model();
        run_until(10);
        for (int i = 0; i < 3; i++) push(24'($urandom));
        clr_stats();
        run_until(FR);
        chk("post_rst_nopop", n_rd, 0);
        clr_stats();
        run_until(2 * FR);
        chk("post_rst_pops", n_rd, 3);
        chk("post_rst_ucnt", vif.underflow_cnt, 5);

        guard = 0;
        while (!s_done && (guard < 100000)) begin
            @(posedge clk);
            guard++;
        end
        chk("sat_done",  s_done, 1);
        chk("sat_no_rd", s_rd, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Large raster, FIFO empty after the lock-on frame start: 70000 underflowing pixels.
    initial begin
        int st, n;
        s_nrst = 1'b1;
        svif.fifo_empty = 1'b1;
        svif.fifo_rdata = '0;
        #1 s_nrst = 1'b0;
        @(posedge clk);
        #1;
        s_nrst = 1'b1;
        svif.fifo_empty = 1'b0;
        svif.fifo_rdata = 24'h123456;
        @(posedge clk);
        #1;
        svif.fifo_empty = 1'b1;
        st = 1;
        n  = 0;
        while ((n < 70000) && (st < 90000)) begin
            bit act;
            act = is_act(st, 256, 288, 3, 3);
            @(posedge clk);
            #1;
            st++;
            if (act) begin
                n++;
                if ((n == 1) || (n == 65534) || (n == 65535) || (n == 65536) || (n == 70000))
                    chk("sat_ucnt", svif.underflow_cnt, (n > 65535) ? 65535 : n);
            end
        end
        chk("sat_npix", n, 70000);
        s_done = 1'b1;
    end

    always @(negedge clk) begin
        if (svif.fifo_rd === 1'b1) s_rd <= s_rd + 1;
    end

endmodule
